prl_rx_ack_seq: RTL
===================

# prl_rx_ack_seq

Receive-side GoodCRC responder sequencer for the USBPD protocol layer. It is the counterpart of the transmit-side protocol timer. After a received message passes CRC, it filters duplicate MessageIDs, waits the inter-frame gap, and requests a GoodCRC transmission from the PHY TX. It aborts if that transmission cannot be started within the tTransmit window. It sits between the PHY RX/TX handshakes and the policy-layer message delivery strobe.

## Interface
- Tifg_TIMEOUT, 600: inter-frame gap in clk cycles (12 MHz x 50 us)
- Ttrn_TIMEOUT, 2304: max EOP-to-GoodCRC-start in clk cycles (12 MHz x 192 us)
- N_WIDTH, 12: timer width; must satisfy 2^N_WIDTH > Ttrn_TIMEOUT
- clk  in  1  single clock, all state on rising edge
- srst  in  1  synchronous reset, active-high
- soft_rst  in  1  protocol soft reset from policy layer, synchronous, active-high
- rx_eop_ok  in  1  one-cycle pulse: non-GoodCRC message received with good CRC
- rx_msgid  in  3  MessageID of that message, valid with rx_eop_ok
- line_busy  in  1  CC line activity detected
- tx_ack  in  1  PHY TX accepted the GoodCRC request (level, sampled in REQ)
- tx_done  in  1  one-cycle pulse: GoodCRC EOP transmitted
- tx_err  in  1  one-cycle pulse: TX collision/abort
- ack_req  out  1  GoodCRC transmit request
- ack_id  out  3  MessageID to place in GoodCRC header
- rx_new  out  1  one-cycle pulse: deliver message (not a duplicate)
- ack_sent  out  1  one-cycle pulse: GoodCRC completed
- ack_fail  out  1  one-cycle pulse: GoodCRC timed out or TX error
- busy  out  1  state != IDLE

## Operation
- States: IDLE, GAP, REQ, SEND. ack_req = (state==REQ); busy = (state!=IDLE).
- Registers: state, timer[N_WIDTH-1:0], ack_id, id_vld (stored-ID valid), pulse flops.
- IDLE + rx_eop_ok:
  - Latch ack_id <= rx_msgid.
  - dup = id_vld & (rx_msgid == ack_id_old).
  - Set id_vld <= 1, timer <= 0, go GAP.
  - rx_new pulses next cycle iff ~dup. Duplicates are still acknowledged.
- GAP: timer increments each cycle.
  - Exit to REQ when timer >= Tifg_TIMEOUT and ~line_busy.
  - line_busy holds GAP but does not reset timer.
- REQ: timer keeps incrementing.
  - tx_ack=1 -> SEND.
  - Else timer >= Ttrn_TIMEOUT -> IDLE with ack_fail pulse.
- Timeout check also applies in GAP: timer >= Ttrn_TIMEOUT -> IDLE, ack_fail.
- Timer saturates at Ttrn_TIMEOUT and never wraps. It is frozen in IDLE and SEND.
- SEND: tx_done -> IDLE with ack_sent pulse; tx_err -> IDLE with ack_fail pulse. No timeout in SEND.
- rx_eop_ok in GAP or REQ: the new message supersedes the old one. Redo latch/dup check against the current ack_id, timer <= 0, go GAP (ack_req drops). rx_new follows the same rule as in IDLE.
- rx_eop_ok in SEND: ignored; no rx_new, ack_id unchanged.
- soft_rst: state <= IDLE, id_vld <= 0, timer <= 0. ack_id is kept. No pulse output that cycle or the next.
- Priority, highest first: srst > soft_rst > rx_eop_ok > tx_ack / tx_done / tx_err > timeout.

## Timing
- Reset values (srst): state IDLE, timer 0, ack_id 0, id_vld 0. All outputs 0.
- rx_eop_ok at cycle T -> state GAP and rx_new=1 at T+1.
- If line idle throughout, ack_req rises at T+1+Tifg_TIMEOUT+1: the timer reaches Tifg at T+1+Tifg and the transition registers one cycle later.
- ack_req holds until the cycle after tx_ack is sampled high. tx_ack and timeout in the same cycle: tx_ack wins.
- Timeout: ack_fail pulses the cycle after the timer is seen >= Ttrn_TIMEOUT, i.e. ack_req low by T+2+Ttrn_TIMEOUT.
- ack_sent / ack_fail / rx_new are registered one-cycle pulses and never coincide with each other in the same cycle, except rx_new with a superseding restart.
- busy falls in the same cycle ack_sent or ack_fail is asserted.

## Test plan
- Nominal: srst, then rx_eop_ok with id 3 at T, line idle; tx_ack 5 cycles after ack_req; tx_done 200 cycles later -> rx_new at T+1, ack_req at T+602, ack_id=3, ack_sent once, busy 0 afterwards.
- Duplicate: two complete exchanges, both id 5 -> second has no rx_new but full GoodCRC with ack_id=5. A third with id 6 -> rx_new. soft_rst then id 6 again -> rx_new.
- Busy line: line_busy high from T+1 to T+1000 -> ack_req rises the cycle after line_busy falls. line_busy held to T+2400 -> no ack_req, ack_fail once, busy 0.
- REQ timeout: tx_ack never asserted -> ack_req high from T+602 until T+2306, then ack_fail pulse; tx_ack on the exact timeout cycle -> SEND, no ack_fail.
- Supersede/ignore: second rx_eop_ok (id 1) during REQ -> ack_req drops, GAP restarts, ack_id=1. rx_eop_ok during SEND -> no effect. tx_err in SEND -> ack_fail.
- Reset mid-operation: srst or soft_rst asserted in REQ together with rx_eop_ok -> IDLE next cycle, ack_req 0, no rx_new/ack_fail pulse.

Source files
------------

// File: rtl/prl_rx_ack_seq.sv
// GoodCRC responder: dedups MessageIDs, waits the IFG, then requests the PHY TX within tTransmit.
// Latency: rx_new 1 cycle after rx_eop_ok, ack_req 1 cycle after the IFG elapses; holds GAP while line_busy, ack_req until tx_ack.
module prl_rx_ack_seq #(
  parameter int Tifg_TIMEOUT = 600,
  parameter int Ttrn_TIMEOUT = 2304,
  parameter int N_WIDTH      = 12
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       soft_rst,
  input  logic       rx_eop_ok,
  input  logic [2:0] rx_msgid,
  input  logic       line_busy,
  input  logic       tx_ack,
  input  logic       tx_done,
  input  logic       tx_err,
  output logic       ack_req,
  output logic [2:0] ack_id,
  output logic       rx_new,
  output logic       ack_sent,
  output logic       ack_fail,
  output logic       busy
);

  localparam logic [N_WIDTH-1:0] TIFG = N_WIDTH'(Tifg_TIMEOUT);
  localparam logic [N_WIDTH-1:0] TTRN = N_WIDTH'(Ttrn_TIMEOUT);

  typedef enum logic [1:0] {IDLE, GAP, REQ, SEND} state_t;

  state_t             state, state_nxt;
  logic [N_WIDTH-1:0] timer, timer_nxt, timer_inc;
  logic [2:0]         ack_id_nxt;
  logic               id_vld, id_vld_nxt;
  logic               rx_new_nxt, ack_sent_nxt, ack_fail_nxt;
  logic               dup;

  // Saturate at the tTransmit limit so a stuck line can never wrap the timer.
  assign timer_inc = (timer >= TTRN) ? TTRN : timer + N_WIDTH'(1);
  assign dup       = id_vld && (rx_msgid == ack_id);
  assign ack_req   = (state == REQ);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    timer_nxt    = timer;
    ack_id_nxt   = ack_id;
    id_vld_nxt   = id_vld;
    rx_new_nxt   = 1'b0;
    ack_sent_nxt = 1'b0;
    ack_fail_nxt = 1'b0;
    if (soft_rst) begin
      state_nxt  = IDLE;
      id_vld_nxt = 1'b0;
      timer_nxt  = '0;
    end else if (rx_eop_ok && state != SEND) begin
      // A new message supersedes any GoodCRC still waiting to go out.
      ack_id_nxt = rx_msgid;
      id_vld_nxt = 1'b1;
      timer_nxt  = '0;
      state_nxt  = GAP;
      rx_new_nxt = !dup;
    end else begin
      case (state)
        GAP: begin
          timer_nxt = timer_inc;
          if (timer >= TTRN) begin
            state_nxt    = IDLE;
            ack_fail_nxt = 1'b1;
          end else if (timer >= TIFG && !line_busy) begin
            state_nxt = REQ;
          end
        end
        REQ: begin
          timer_nxt = timer_inc;
          if (tx_ack) begin
            state_nxt = SEND;
          end else if (timer >= TTRN) begin
            state_nxt    = IDLE;
            ack_fail_nxt = 1'b1;
          end
        end
        SEND: begin
          if (tx_done) begin
            state_nxt    = IDLE;
            ack_sent_nxt = 1'b1;
          end else if (tx_err) begin
            state_nxt    = IDLE;
            ack_fail_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state    <= IDLE;
      timer    <= '0;
      ack_id   <= 3'd0;
      id_vld   <= 1'b0;
      rx_new   <= 1'b0;
      ack_sent <= 1'b0;
      ack_fail <= 1'b0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      ack_id   <= ack_id_nxt;
      id_vld   <= id_vld_nxt;
      rx_new   <= rx_new_nxt;
      ack_sent <= ack_sent_nxt;
      ack_fail <= ack_fail_nxt;
    end
  end

endmodule
